// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
// Holds the address-width helper and the default almost-empty/almost-full margins.
package sync_fifo_pkg;

  // Default distance of the almost-full threshold below DEPTH
  localparam int AF_MARGIN_DEFAULT = 2;

  // Default almost-empty threshold (occupancy at or below this level)
  localparam int AE_MARGIN_DEFAULT = 2;

  // Number of address bits needed to index 'value' entries (ceil(log2(value)))
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Storage array for sync_fifo_param: DEPTH x DATA_W, one synchronous write
// port and one synchronous registered read port on a single clock.
// The array itself is never reset; only the read-data register is.
module fifo_ram_2p
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wrEn_i,
  input  logic [clog2(DEPTH)-1:0]   wrAddr_i,
  input  logic [DATA_W-1:0]         wrData_i,
  input  logic                      rdEn_i,
  input  logic [clog2(DEPTH)-1:0]   rdAddr_i,
  output logic [DATA_W-1:0]         rdData_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdData_q;

  // Write port: store incoming data at the write address when enabled
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  // Read port: capture the addressed entry on an enabled read, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      rdData_q <= '0;
    end else if (rdEn_i) begin
      rdData_q <= mem_q[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with wrap-bit pointers, registered
// occupancy count, almost-full/almost-empty thresholds and 1-cycle read latency.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// outputs that clear only on reset.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - AF_MARGIN_DEFAULT,
  parameter int AE_LEVEL = AE_MARGIN_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    full,
  output logic                    almost_full,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    empty,
  output logic                    almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                    overflow,
  output logic                    underflow,
`endif
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] count_q, count_d;
  logic          rdValid_q, rdValid_d;
  logic          wrAccept;
  logic          rdAccept;

  // Full when pointers differ only in the wrap bit, empty when identical
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q == {~rdPtr_q[AW], rdPtr_q[AW-1:0]});

  // Requests are only honoured when the FIFO can serve them; there is no bypass
  assign wrAccept = wr_en && !full;
  assign rdAccept = rd_en && !empty;

  // Next-state for pointers, occupancy and read-valid
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    rdValid_d = rdAccept;
    if (wrAccept) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (rdAccept) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    case ({wrAccept, rdAccept})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and read-valid registers; reset wins over any request
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rdValid_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      rdValid_q <= rdValid_d;
    end
  end

  assign count        = count_q;
  assign rd_valid     = rdValid_q;
  assign almost_full  = (count_q >= PW'(AF_LEVEL));
  assign almost_empty = (count_q <= PW'(AE_LEVEL));

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: set on a request the FIFO could not serve
  always_comb begin
    overflow_d  = overflow_q  | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);
  end

  // Error flag registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  fifo_ram_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .wrEn_i   (wrAccept && !rst),
    .wrAddr_i (wrPtr_q[AW-1:0]),
    .wrData_i (wr_data),
    .rdEn_i   (rdAccept && !rst),
    .rdAddr_i (rdPtr_q[AW-1:0]),
    .rdData_o (rd_data)
  );

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 8, entry count, power of two, 2..1024.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have ports: clk in 1 (single clock); rst in 1 (reset is synchronous and active-high).
REQ-006 SHALL have ports: wr_en in 1 write request; wr_data in DATA_W write data; full out 1; almost_full out 1.
REQ-007 SHALL have ports: rd_en in 1 read request; rd_data out DATA_W; rd_valid out 1; empty out 1; almost_empty out 1.
REQ-008 SHALL have port count out clog2(DEPTH)+1 current occupancy.
REQ-009 SHALL have ports overflow out 1 and underflow out 1 when FIFO_ERR_FLAGS_EN is defined, and no such ports otherwise.

Function
REQ-010 SHALL use write and read pointers of clog2(DEPTH)+1 bits, with the MSB as a wrap bit and modulo-2^(clog2(DEPTH)+1) increment.
REQ-011 SHALL drive empty = (wptr == rptr) and full = (wptr MSB inverted, remaining bits equal to rptr), both combinational from registered pointers.
REQ-012 SHALL accept a write iff wr_en && !full, storing wr_data at wptr[low bits] and incrementing wptr on the same edge.
REQ-013 SHALL accept a read iff rd_en && !empty, incrementing rptr on that edge.
REQ-014 SHALL register rd_data from the head entry on an accepted read, giving 1-cycle latency, and pulse rd_valid=1 for exactly that following cycle.
REQ-015 SHALL, on cycles with no accepted read, hold rd_data at its last value and drive rd_valid=0.
REQ-016 SHALL, when a write and a read are both accepted in the same cycle, update both pointers and leave count unchanged.
REQ-017 SHALL accept only the read when full with wr_en=rd_en=1, and only the write when empty with wr_en=rd_en=1; there is no bypass.
REQ-018 SHALL maintain count as a register: +1 on write-only, -1 on read-only, unchanged otherwise; count SHALL equal wptr-rptr at all times.
REQ-019 SHALL derive almost_full and almost_empty combinationally from count against AF_LEVEL and AE_LEVEL.
REQ-020 SHALL never modify memory contents or pointers on a rejected request.

Reset
REQ-021 SHALL, on rst=1 at posedge clk, set wptr=rptr=0, count=0, rd_data=0, rd_valid=0, and clear overflow and underflow; rst SHALL take priority over any request in that cycle.
REQ-022 SHALL NOT clear memory contents on reset; after reset, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-023 SHALL discard any in-flight contents on reset mid-operation, with no rd_valid pulse in the cycle following reset.

Configuration
REQ-024 SHALL compile in sticky error flags when FIFO_ERR_FLAGS_EN is defined: overflow sets on wr_en && full, underflow sets on rd_en && empty, and both clear only on rst.
REQ-025 SHALL, without FIFO_ERR_FLAGS_EN, omit the flags and their logic; rejected requests are silently ignored.

Structure
REQ-026 SHALL take shared constants and helpers (clog2 function, default AE/AF margins) from package sync_fifo_pkg.
REQ-027 SHALL place storage in sub-module fifo_ram_2p: DEPTH x DATA_W, one synchronous write port and one synchronous read port on clk.
REQ-028 SHALL keep pointer, count and flag logic in sync_fifo_param itself.

Verification (DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-029 SHALL verify: after rst, write 0x11..0x88 over 8 cycles -> full=1 after the 8th edge, count=8, almost_full=1 from count=6.
REQ-030 SHALL verify: from full, read 8 times -> rd_data 0x11..0x88 in order, each one cycle after its read, with rd_valid pulsing each time; then empty=1.
REQ-031 SHALL verify: at count=4, wr_en=rd_en=1 for 20 cycles -> count stays 4 and the data order is preserved across pointer wrap.
REQ-032 SHALL verify: at full, wr_en=rd_en=1 -> only the read is accepted and count=7; at empty, both asserted -> only the write is accepted and count=1 with rd_valid=0.
REQ-033 SHALL verify, with FIFO_ERR_FLAGS_EN: write while full -> overflow=1 and held, contents unchanged; read while empty -> underflow=1; rst clears both.
REQ-034 SHALL verify: rst asserted at count=5 during a read -> next cycle count=0, empty=1, rd_valid=0.
